// File: rtl/tq_pkg.sv
`default_nettype none
// ============================================================================
// tq_pkg : shared types, encodings and lookup tables for the TQ scheduler
// Revision: 1.0
// ============================================================================
package tq_pkg;

    localparam logic [1:0] TQ_4  = 2'd0;
    localparam logic [1:0] TQ_8  = 2'd1;
    localparam logic [1:0] TQ_16 = 2'd2;
    localparam logic [1:0] TQ_32 = 2'd3;

    localparam int         QP_MAX_DEF = 51;
    localparam logic [7:0] RND_INTRA  = 8'd171;
    localparam logic [7:0] RND_INTER  = 8'd85;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_CFG  = 2'd2,
        ST_WAIT = 2'd3
    } tq_state_e;

    function automatic logic [15:0] fwd_scale(input logic [2:0] m);
        case (m)
            3'd0:    fwd_scale = 16'd26214;
            3'd1:    fwd_scale = 16'd23302;
            3'd2:    fwd_scale = 16'd20560;
            3'd3:    fwd_scale = 16'd18396;
            3'd4:    fwd_scale = 16'd16384;
            3'd5:    fwd_scale = 16'd14564;
            default: fwd_scale = 16'd0;
        endcase
    endfunction

    function automatic logic [6:0] inv_scale(input logic [2:0] m);
        case (m)
            3'd0:    inv_scale = 7'd40;
            3'd1:    inv_scale = 7'd45;
            3'd2:    inv_scale = 7'd51;
            3'd3:    inv_scale = 7'd57;
            3'd4:    inv_scale = 7'd64;
            3'd5:    inv_scale = 7'd72;
            default: inv_scale = 7'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tq_qp_div6.sv
`default_nettype none
// ============================================================================
// tq_qp_div6 : iterative subtract-by-6 divider producing qp/6 and qp%6
// Revision: 1.0
// ============================================================================
module tq_qp_div6 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [5:0] i_qp,
    output logic       o_done,
    output logic [3:0] o_div,
    output logic [2:0] o_mod
);

    logic [5:0] r_rem;
    logic [3:0] r_div;
    logic       r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= 6'd0;
            r_div  <= 4'd0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_qp;
            r_div  <= 4'd0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_rem >= 6'd6) begin
                r_rem <= r_rem - 6'd6;
                r_div <= r_div + 4'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    // Quotient and remainder are final in the cycle the remainder drops below 6.
    assign o_done = r_busy && (r_rem < 6'd6);
    assign o_div  = r_div;
    assign o_mod  = r_rem[2:0];

endmodule
`default_nettype wire

// File: rtl/tq_qp_sched.sv
`default_nettype none
// ============================================================================
// tq_qp_sched : per-TU scheduler computing quant/dequant scale, shift, offset
// Revision: 1.0
// ============================================================================
module tq_qp_sched
    import tq_pkg::*;
#(
    parameter int QP_MAX   = QP_MAX_DEF,
    parameter int SCALE_W  = 16,
    parameter int OFFSET_W = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [5:0]          req_qp_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_intra_i,
    input  logic                req_inv_i,
    output logic [SCALE_W-1:0]  q_scale_o,
    output logic [4:0]          q_shift_o,
    output logic [OFFSET_W-1:0] q_offset_o,
    output logic                cfg_valid_o,
    output logic                tq_start_o,
    input  logic                tq_done_i,
    output logic                busy_o
);

    tq_state_e            r_state, w_next;
    logic [1:0]           r_size;
    logic                 r_intra, r_inv;
    logic [5:0]           r_qp;
    logic                 r_cache_vld;
    logic [5:0]           r_cache_qp;
    logic [3:0]           r_cache_div;
    logic [2:0]           r_cache_mod;
    logic [SCALE_W-1:0]   r_scale;
    logic [4:0]           r_shift;
    logic [OFFSET_W-1:0]  r_offset;

    logic [5:0]           w_qp_c;
    logic                 w_hit, w_div_start, w_load, w_div_done;
    logic [3:0]           w_div_q, w_div;
    logic [2:0]           w_div_r, w_mod;
    logic [1:0]           w_size;
    logic                 w_intra, w_inv;
    logic [4:0]           w_fwd_amt;
    logic [7:0]           w_rnd;
    logic [SCALE_W-1:0]   w_scale;
    logic [4:0]           w_shift;
    logic [OFFSET_W-1:0]  w_offset;

    assign w_qp_c = (req_qp_i > 6'(QP_MAX)) ? 6'(QP_MAX) : req_qp_i;
    assign w_hit  = r_cache_vld && (r_cache_qp == w_qp_c);

    tq_qp_div6 u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_qp    (w_qp_c),
        .o_done  (w_div_done),
        .o_div   (w_div_q),
        .o_mod   (w_div_r)
    );

    // A cache hit loads the config straight from the live request and cached div/mod.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_size  = req_size_i;
            w_intra = req_intra_i;
            w_inv   = req_inv_i;
            w_div   = r_cache_div;
            w_mod   = r_cache_mod;
        end else begin
            w_size  = r_size;
            w_intra = r_intra;
            w_inv   = r_inv;
            w_div   = w_div_q;
            w_mod   = w_div_r;
        end
    end

    always_comb begin
        w_fwd_amt = 5'd10 - {3'b000, w_size} + {1'b0, w_div};
        w_rnd     = w_intra ? RND_INTRA : RND_INTER;
        if (w_inv) begin
            w_scale  = SCALE_W'(inv_scale(w_mod)) << w_div;
            w_shift  = {3'b000, w_size} + 5'd1;
            w_offset = OFFSET_W'(1) << w_size;
        end else begin
            w_scale  = SCALE_W'(fwd_scale(w_mod));
            w_shift  = 5'd19 - {3'b000, w_size} + {1'b0, w_div};
            w_offset = OFFSET_W'(w_rnd) << w_fwd_amt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        w_load      = 1'b0;
        req_ready_o = 1'b0;
        cfg_valid_o = 1'b0;
        tq_start_o  = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    if (w_hit) begin
                        w_load = 1'b1;
                        w_next = ST_CFG;
                    end else begin
                        w_div_start = 1'b1;
                        w_next      = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_load = 1'b1;
                    w_next = ST_CFG;
                end
            end
            ST_CFG: begin
                cfg_valid_o = 1'b1;
                tq_start_o  = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                cfg_valid_o = 1'b1;
                if (tq_done_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size      <= 2'd0;
            r_intra     <= 1'b0;
            r_inv       <= 1'b0;
            r_qp        <= 6'd0;
            r_cache_vld <= 1'b0;
            r_cache_qp  <= 6'd0;
            r_cache_div <= 4'd0;
            r_cache_mod <= 3'd0;
            r_scale     <= '0;
            r_shift     <= 5'd0;
            r_offset    <= '0;
        end else begin
            if (r_state == ST_IDLE && req_valid_i) begin
                r_size  <= req_size_i;
                r_intra <= req_intra_i;
                r_inv   <= req_inv_i;
                r_qp    <= w_qp_c;
            end
            if (r_state == ST_DIV && w_div_done) begin
                r_cache_vld <= 1'b1;
                r_cache_qp  <= r_qp;
                r_cache_div <= w_div_q;
                r_cache_mod <= w_div_r;
            end
            if (w_load) begin
                r_scale  <= w_scale;
                r_shift  <= w_shift;
                r_offset <= w_offset;
            end
        end
    end

    assign q_scale_o  = r_scale;
    assign q_shift_o  = r_shift;
    assign q_offset_o = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_tq_qp_sched.sv
`default_nettype none
// ============================================================================
// tb_tq_qp_sched : vector table, protocol corners and randomized model check
// Revision: 1.0
// ============================================================================
module tb_tq_qp_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [5:0]  req_qp_i = 6'd0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_intra_i = 1'b0;
    logic        req_inv_i = 1'b0;
    logic [15:0] q_scale_o;
    logic [4:0]  q_shift_o;
    logic [27:0] q_offset_o;
    logic        cfg_valid_o;
    logic        tq_start_o;
    logic        tq_done_i = 1'b0;
    logic        busy_o;

    tq_qp_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_qp_i    (req_qp_i),
        .req_size_i  (req_size_i),
        .req_intra_i (req_intra_i),
        .req_inv_i   (req_inv_i),
        .q_scale_o   (q_scale_o),
        .q_shift_o   (q_shift_o),
        .q_offset_o  (q_offset_o),
        .cfg_valid_o (cfg_valid_o),
        .tq_start_o  (tq_start_o),
        .tq_done_i   (tq_done_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         m_cache_vld = 1'b0;
    logic [5:0] m_cache_qp = 6'd0;

    typedef struct {
        logic [5:0]  qp;
        logic [1:0]  sz;
        logic        intra;
        logic        inv;
        bit          hold;
        bit          dcfg;
        int          lat;
        logic [15:0] sc;
        logic [4:0]  sh;
        logic [27:0] off;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, exp);
        end
    endtask

    function automatic logic [5:0] clamp(input logic [5:0] qp);
        return (qp > 6'd51) ? 6'd51 : qp;
    endfunction

    // Arithmetic reference: qp split with / and %, tables as plain arrays.
    function automatic void model(input logic [5:0] qp, input logic [1:0] sz, input logic intra,
                                  input logic inv, output int lat, output logic [15:0] sc,
                                  output logic [4:0] sh, output logic [27:0] off);
        int fwd[6] = '{26214, 23302, 20560, 18396, 16384, 14564};
        int lvl[6] = '{40, 45, 51, 57, 64, 72};
        int q, d, m, s;
        q = int'(clamp(qp));
        d = q / 6;
        m = q % 6;
        s = int'(sz);
        lat = (m_cache_vld && int'(m_cache_qp) == q) ? 1 : d + 2;
        if (!inv) begin
            sc  = 16'(fwd[m]);
            sh  = 5'(19 - s + d);
            off = 28'((intra ? 171 : 85) * (1 << (10 - s + d)));
        end else begin
            sc  = 16'(lvl[m] * (1 << d));
            sh  = 5'(s + 1);
            off = 28'(1 << s);
        end
    endfunction

    task automatic do_tu(input string nm, input logic [5:0] qp, input logic [1:0] sz,
                         input logic intra, input logic inv, input bit hold, input bit dcfg,
                         input int elat, input logic [15:0] esc, input logic [4:0] esh,
                         input logic [27:0] eoff);
        int lat;
        bit seen;
        @(negedge clk);
        chk(nm, "ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_qp_i    = qp;
        req_size_i  = sz;
        req_intra_i = intra;
        req_inv_i   = inv;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = hold;
        req_qp_i    = 6'($urandom);
        req_size_i  = 2'($urandom);
        req_intra_i = 1'($urandom);
        req_inv_i   = 1'($urandom);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (tq_start_o) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk(nm, "latency", 32'(lat), 32'(elat));
        chk(nm, "scale", 32'(q_scale_o), 32'(esc));
        chk(nm, "shift", 32'(q_shift_o), 32'(esh));
        chk(nm, "offset", 32'(q_offset_o), 32'(eoff));
        chk(nm, "cfg_valid", 32'(cfg_valid_o), 32'd1);
        if (dcfg) tq_done_i = 1'b1;
        @(negedge clk);
        tq_done_i = 1'b0;
        chk(nm, "start_pulse", 32'(tq_start_o), 32'd0);
        chk(nm, "wait_busy", 32'(busy_o), 32'd1);
        chk(nm, "wait_ready", 32'(req_ready_o), 32'd0);
        repeat (2) @(negedge clk);
        chk(nm, "wait_start", 32'(tq_start_o), 32'd0);
        chk(nm, "wait_hold", 32'(q_scale_o), 32'(esc));
        req_valid_i = 1'b0;
        tq_done_i   = 1'b1;
        @(negedge clk);
        tq_done_i = 1'b0;
        chk(nm, "done_ready", 32'(req_ready_o), 32'd1);
        chk(nm, "done_cfgv", 32'(cfg_valid_o), 32'd0);
        chk(nm, "done_offset", 32'(q_offset_o), 32'(eoff));
        m_cache_vld = 1'b1;
        m_cache_qp  = clamp(qp);
    endtask

    task automatic do_model_tu(input string nm, input logic [5:0] qp, input logic [1:0] sz,
                               input logic intra, input logic inv);
        int          lat;
        logic [15:0] sc;
        logic [4:0]  sh;
        logic [27:0] off;
        model(qp, sz, intra, inv, lat, sc, sh, off);
        do_tu(nm, qp, sz, intra, inv, 1'b0, 1'b0, lat, sc, sh, off);
    endtask

    initial begin
        int starts;
        tbl[0] = '{qp: 6'd22, sz: 2'd0, intra: 1'b1, inv: 1'b0, hold: 1'b0, dcfg: 1'b0,
                   lat: 5,  sc: 16'd16384, sh: 5'd22, off: 28'd1400832};
        tbl[1] = '{qp: 6'd22, sz: 2'd0, intra: 1'b1, inv: 1'b0, hold: 1'b1, dcfg: 1'b0,
                   lat: 1,  sc: 16'd16384, sh: 5'd22, off: 28'd1400832};
        tbl[2] = '{qp: 6'd51, sz: 2'd1, intra: 1'b0, inv: 1'b1, hold: 1'b0, dcfg: 1'b1,
                   lat: 10, sc: 16'd14592, sh: 5'd2,  off: 28'd2};
        tbl[3] = '{qp: 6'd60, sz: 2'd3, intra: 1'b0, inv: 1'b0, hold: 1'b0, dcfg: 1'b0,
                   lat: 1,  sc: 16'd18396, sh: 5'd24, off: 28'd2785280};
        tbl[4] = '{qp: 6'd0,  sz: 2'd3, intra: 1'b0, inv: 1'b1, hold: 1'b1, dcfg: 1'b1,
                   lat: 2,  sc: 16'd40,    sh: 5'd4,  off: 28'd8};
        tbl[5] = '{qp: 6'd5,  sz: 2'd2, intra: 1'b1, inv: 1'b0, hold: 1'b0, dcfg: 1'b0,
                   lat: 2,  sc: 16'd14564, sh: 5'd17, off: 28'd43776};

        repeat (2) @(negedge clk);
        chk("reset", "ready", 32'(req_ready_o), 32'd1);
        chk("reset", "busy", 32'(busy_o), 32'd0);
        chk("reset", "cfg_valid", 32'(cfg_valid_o), 32'd0);
        chk("reset", "start", 32'(tq_start_o), 32'd0);
        chk("reset", "scale", 32'(q_scale_o), 32'd0);
        chk("reset", "offset", 32'(q_offset_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_tu($sformatf("vec%0d", i), tbl[i].qp, tbl[i].sz, tbl[i].intra, tbl[i].inv,
                  tbl[i].hold, tbl[i].dcfg, tbl[i].lat, tbl[i].sc, tbl[i].sh, tbl[i].off);
        end

        // Reset in the middle of a qp=30 division.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_qp_i    = 6'd30;
        req_size_i  = 2'd1;
        req_intra_i = 1'b1;
        req_inv_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_div", "busy_pre", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_div", "ready", 32'(req_ready_o), 32'd1);
        chk("rst_div", "busy", 32'(busy_o), 32'd0);
        chk("rst_div", "scale", 32'(q_scale_o), 32'd0);
        chk("rst_div", "shift", 32'(q_shift_o), 32'd0);
        chk("rst_div", "offset", 32'(q_offset_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_cache_vld = 1'b0;
        starts = 0;
        repeat (12) begin
            @(negedge clk);
            if (tq_start_o) starts++;
        end
        chk("rst_div", "no_start", 32'(starts), 32'd0);
        do_model_tu("post_rst_qp0", 6'd0, 2'd0, 1'b0, 1'b0);
        do_model_tu("post_rst_qp30", 6'd30, 2'd1, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] qp;
            qp = ($urandom_range(0, 1) == 0 && m_cache_vld) ? m_cache_qp : 6'($urandom_range(0, 63));
            do_model_tu($sformatf("rnd%0d", i), qp, 2'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
